// File: rtl/blockram_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the block RAM request front-end.
// Byte lane width, response buffer depth and controller states live here.
package blockram_access_ctrl_pkg;

    localparam int unsigned BYTE_LEN_IN_BITS = 8;
    localparam int unsigned RESP_BUF_DEPTH   = 2;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/blockram_access_ctrl_response_fifo.sv
// Two-deep response buffer holding {set address, read data} pairs.
// Slot 0 is always the head, so the head is stable until it is popped.
module response_fifo_2entry
    import blockram_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occupancy
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] slot0;
    logic [ENTRY_W-1:0] slot1;
    logic [ENTRY_W-1:0] entry_in;
    logic [1:0]         count;
    logic               pop_ok;
    logic               push_ok;

    assign entry_in = {push_addr, push_data};
    assign pop_ok   = pop && (count != 2'd0);
    assign push_ok  = push && ((count != 2'(RESP_BUF_DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) slot0 <= entry_in;
                    else               slot1 <= entry_in;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Pop and push together: the new entry lands behind whatever remains.
                    if (count == 2'd1) begin
                        slot0 <= entry_in;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= entry_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid     = (count != 2'd0);
    assign head_addr = slot0[ENTRY_W-1:DATA_W];
    assign head_data = slot0[DATA_W-1:0];
    assign occupancy = count;

endmodule

// File: rtl/blockram_access_ctrl.sv
// Valid/ready request front-end for a single-port block RAM with a 2-entry read response buffer.
// Define BLOCKRAM_INIT_EN to zero every set after reset before traffic is accepted.
module blockram_access_ctrl
    import blockram_access_ctrl_pkg::*;
#(
    parameter int unsigned SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int unsigned NUM_SET                   = 64,
    parameter int unsigned SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int unsigned WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 reset_n_in,
    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic                                 request_write_in,
    input  logic [WRITE_MASK_LEN-1:0]            request_write_mask_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_write_data_in,
    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     response_set_addr_out,
    output logic                                 access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_in,
    output logic                                 init_done_out
);

    ctrl_state_e                      state_q;
    ctrl_state_e                      state_d;
    logic                             init_done_q;
    logic                             inflight_q;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] inflight_addr_q;
    logic [1:0]                       occupancy;
    logic                             resp_pop;
    logic [2:0]                       credit_used;
    logic                             read_credit;
    logic                             accept;
    logic                             accept_read;

`ifdef BLOCKRAM_INIT_EN
    logic [SET_PTR_WIDTH_IN_BITS-1:0] init_set_q;
    logic                             init_last;

    assign init_last = (init_set_q == SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1));
`endif

    // Buffered responses plus the read still coming out of the RAM must fit in the buffer.
    assign resp_pop          = response_valid_out && response_ready_in;
    assign credit_used       = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, resp_pop};
    assign read_credit       = (credit_used < 3'(RESP_BUF_DEPTH));
    assign request_ready_out = (state_q == ST_READY) && (request_write_in || read_credit);
    assign accept            = request_valid_in && request_ready_out;
    assign accept_read       = accept && !request_write_in;

    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef BLOCKRAM_INIT_EN
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  if (init_last) state_d = ST_READY;
`else
            ST_RESET: state_d = ST_READY;
            ST_INIT:  state_d = ST_READY;
`endif
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        access_en_out       = 1'b0;
        write_en_out        = '0;
        access_set_addr_out = '0;
        write_entry_out     = '0;
        if (accept) begin
            access_en_out       = 1'b1;
            write_en_out        = request_write_in ? request_write_mask_in : '0;
            access_set_addr_out = request_set_addr_in;
            write_entry_out     = request_write_data_in;
        end
`ifdef BLOCKRAM_INIT_EN
        if (state_q == ST_INIT) begin
            access_en_out       = 1'b1;
            write_en_out        = '1;
            access_set_addr_out = init_set_q;
            write_entry_out     = '0;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= ST_RESET;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= (state_d == ST_READY);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q <= accept_read;
            if (accept_read) inflight_addr_q <= request_set_addr_in;
        end
    end

`ifdef BLOCKRAM_INIT_EN
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            init_set_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_set_q <= init_last ? '0 : init_set_q + 1'b1;
        end
    end
`endif

    assign init_done_out = init_done_q;

    response_fifo_2entry #(
        .ADDR_W(SET_PTR_WIDTH_IN_BITS),
        .DATA_W(SINGLE_ENTRY_SIZE_IN_BITS)
    ) u_resp_fifo (
        .clk      (clk_in),
        .rst_n    (reset_n_in),
        .push     (inflight_q),
        .push_addr(inflight_addr_q),
        .push_data(read_entry_in),
        .pop      (resp_pop),
        .valid    (response_valid_out),
        .head_addr(response_set_addr_out),
        .head_data(response_data_out),
        .occupancy(occupancy)
    );

endmodule

// File: tb/tb_blockram_access_ctrl.sv
// Scoreboard bench for blockram_access_ctrl with a behavioural byte-masked block RAM.
// Define BLOCKRAM_INIT_EN at compile time to also exercise the post-reset zeroing sweep.
module tb_blockram_access_ctrl;

    localparam int NS = 64;
    localparam int AW = 6;
    localparam int DW = 64;
    localparam int ML = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [ML-1:0] req_mask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] resp_addr;
    logic          access_en;
    logic [ML-1:0] write_en;
    logic [AW-1:0] access_addr;
    logic [DW-1:0] write_entry;
    logic [DW-1:0] read_entry;
    logic          init_done;

    int vectors    = 0;
    int miscompares = 0;

    resp_t         exp_q[$];
    logic [DW-1:0] ref_mem [NS];

    logic          s_acc, s_pop, s_valid, s_ready, s_access, s_init_done;
    logic [DW-1:0] s_data, s_wentry;
    logic [AW-1:0] s_addr, s_aaddr;
    logic [ML-1:0] s_wen;

    blockram_access_ctrl #(
        .SINGLE_ENTRY_SIZE_IN_BITS(DW),
        .NUM_SET(NS)
    ) dut (
        .clk_in               (clk),
        .reset_n_in           (rst_n),
        .request_valid_in     (req_valid),
        .request_ready_out    (req_ready),
        .request_write_in     (req_write),
        .request_write_mask_in(req_mask),
        .request_set_addr_in  (req_addr),
        .request_write_data_in(req_data),
        .response_valid_out   (resp_valid),
        .response_ready_in    (resp_ready),
        .response_data_out    (resp_data),
        .response_set_addr_out(resp_addr),
        .access_en_out        (access_en),
        .write_en_out         (write_en),
        .access_set_addr_out  (access_addr),
        .write_entry_out      (write_entry),
        .read_entry_in        (read_entry),
        .init_done_out        (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input int i);
        return 64'hC0DE_0000_5A5A_0000 ^ {32'(i), 32'(i * 3)};
    endfunction

    // Behavioural single-port RAM: one-cycle read latency, byte write enables.
    logic [DW-1:0] ram [NS];
    logic [DW-1:0] ram_q;
    logic          ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < NS; i++) ram[i] <= pattern(i);
            ram_loaded <= 1'b1;
        end else if (access_en) begin
            for (int b = 0; b < ML; b++)
                if (write_en[b]) ram[access_addr][b*8 +: 8] <= write_entry[b*8 +: 8];
            ram_q <= ram[access_addr];
        end
    end
    assign read_entry = ram_q;

    // Samples the settled cycle, updates the reference memory and scoreboard, then advances.
    task automatic tick();
        #2;
        s_acc       = req_valid && req_ready;
        s_pop       = resp_valid && resp_ready;
        s_valid     = resp_valid;
        s_ready     = req_ready;
        s_data      = resp_data;
        s_addr      = resp_addr;
        s_access    = access_en;
        s_wen       = write_en;
        s_aaddr     = access_addr;
        s_wentry    = write_entry;
        s_init_done = init_done;
        if (s_acc && req_write) begin
            for (int b = 0; b < ML; b++)
                if (req_mask[b]) ref_mem[req_addr][b*8 +: 8] = req_data[b*8 +: 8];
        end else if (s_acc) begin
            exp_q.push_back('{addr: req_addr, data: ref_mem[req_addr]});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [ML-1:0] m,
                         input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_mask  = m;
        req_data  = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_mask  = '0;
        req_data  = '0;
    endtask

    task automatic wait_init_done();
        for (int k = 0; k < 200 && !init_done; k++) tick();
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_timeout: init_done=%b required 1", init_done);
        end
`ifdef BLOCKRAM_INIT_EN
        for (int i = 0; i < NS; i++) ref_mem[i] = '0;
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive(1'b0, 6'd1, '0, '0);
        tick();
        vectors++;
        if ({s_ready, s_access, s_wen, s_valid, s_data, s_addr, s_init_done} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b acc=%b wen=%h rv=%b rd=%h ra=%0d done=%b required all 0",
                     s_ready, s_access, s_wen, s_valid, s_data, s_addr, s_init_done);
        end
        idle();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (s_ready !== 1'b0 || s_init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b done=%b required 0/0", s_ready, s_init_done);
        end
`ifndef BLOCKRAM_INIT_EN
        tick();
        vectors++;
        if (s_ready !== 1'b1 || s_init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL first_edge_ready: ready=%b done=%b required 1/1", s_ready, s_init_done);
        end
`endif
    endtask

`ifdef BLOCKRAM_INIT_EN
    task automatic test_init_sweep();
        for (int i = 0; i < NS; i++) begin
            tick();
            vectors++;
            if (s_ready !== 1'b0 || s_access !== 1'b1 || s_wen !== '1 || s_aaddr !== AW'(i)
                || s_wentry !== '0 || s_init_done !== 1'b0) begin
                miscompares++;
                $display("FAIL init_sweep[%0d]: ready=%b acc=%b wen=%h set=%0d wd=%h done=%b required 0/1/ff/%0d/0/0",
                         i, s_ready, s_access, s_wen, s_aaddr, s_wentry, s_init_done, i);
            end
        end
        tick();
        vectors++;
        if (s_init_done !== 1'b1 || s_ready !== 1'b1 || s_access !== 1'b0) begin
            miscompares++;
            $display("FAIL init_end: done=%b ready=%b acc=%b required 1/1/0", s_init_done, s_ready, s_access);
        end
        for (int i = 0; i < NS; i++) ref_mem[i] = '0;
    endtask

    task automatic test_init_read();
        resp_t e;
        resp_ready = 1'b1;
        drive(1'b0, 6'd63, '0, '0);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (s_pop) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL init_read: unexpected response set %0d data %h", s_addr, s_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_addr !== 6'd63 || s_data !== 64'h0 || s_addr !== e.addr || s_data !== e.data) begin
                        miscompares++;
                        $display("FAIL init_read: got set %0d data %h required set 63 data 0", s_addr, s_data);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL init_read_missing: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_init_restart();
        bit found = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 100 && !found; k++) begin
            #2;
            if (access_en && access_addr == 6'd20) found = 1;
            else @(negedge clk);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL restart_find20: set 20 never swept, required within 100 cycles");
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (access_en !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_in_reset: acc=%b ready=%b required 0/0", access_en, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (s_access !== 1'b1 || s_aaddr !== '0 || s_wen !== '1) begin
            miscompares++;
            $display("FAIL restart_from0: acc=%b set=%0d wen=%h required 1/0/ff", s_access, s_aaddr, s_wen);
        end
        wait_init_done();
    endtask
`endif

    task automatic test_write_read();
        resp_t e;
        resp_ready = 1'b1;
        drive(1'b1, 6'd5, 8'hFF, 64'h1122334455667788);
        tick();
        vectors++;
        if (s_acc !== 1'b1 || s_access !== 1'b1 || s_wen !== 8'hFF || s_aaddr !== 6'd5
            || s_wentry !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL write_ram_side: acc=%b en=%b wen=%h set=%0d wd=%h required 1/1/ff/5/1122334455667788",
                     s_acc, s_access, s_wen, s_aaddr, s_wentry);
        end
        drive(1'b0, 6'd5, 8'hFF, 64'hDEAD);
        tick();
        vectors++;
        if (s_acc !== 1'b1 || s_access !== 1'b1 || s_wen !== 8'h00 || s_aaddr !== 6'd5) begin
            miscompares++;
            $display("FAIL read_ram_side: acc=%b en=%b wen=%h set=%0d required 1/1/00/5",
                     s_acc, s_access, s_wen, s_aaddr);
        end
        idle();
        tick();
        vectors++;
        if (s_valid !== 1'b0 || s_access !== 1'b0 || s_wen !== 8'h00) begin
            miscompares++;
            $display("FAIL latency_n1: rv=%b acc=%b wen=%h required 0/0/00", s_valid, s_access, s_wen);
        end
        tick();
        vectors++;
        if (s_valid !== 1'b1 || s_data !== 64'h1122334455667788 || s_addr !== 6'd5) begin
            miscompares++;
            $display("FAIL latency_n2: rv=%b data=%h set=%0d required 1/1122334455667788/5", s_valid, s_data, s_addr);
        end
        if (s_pop && exp_q.size() != 0) begin
            vectors++;
            e = exp_q.pop_front();
            if (s_addr !== e.addr || s_data !== e.data) begin
                miscompares++;
                $display("FAIL wr_rd_scoreboard: got %0d/%h required %0d/%h", s_addr, s_data, e.addr, e.data);
            end
        end
        tick();
        vectors++;
        if (s_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_drained: rv=%b required 0", s_valid);
        end
    endtask

    task automatic test_mask();
        resp_t e;
        resp_ready = 1'b1;
        drive(1'b1, 6'd3, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
        tick();
        drive(1'b1, 6'd3, 8'h0F, 64'h0);
        tick();
        drive(1'b1, 6'd3, 8'h00, 64'h5555555555555555);
        tick();
        vectors++;
        if (s_acc !== 1'b1 || s_access !== 1'b1 || s_wen !== 8'h00) begin
            miscompares++;
            $display("FAIL zero_mask_write: acc=%b en=%b wen=%h required 1/1/00", s_acc, s_access, s_wen);
        end
        drive(1'b0, 6'd3, '0, '0);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            if (s_pop) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL mask_read: unexpected response set %0d data %h", s_addr, s_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_data !== 64'hAAAAAAAA00000000 || s_addr !== 6'd3 || s_data !== e.data) begin
                        miscompares++;
                        $display("FAIL mask_read: got set %0d data %h required set 3 data aaaaaaaa00000000",
                                 s_addr, s_data);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mask_missing: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        resp_t e;
        int pops = 0;
        int first_pop = -1;
        int last_pop = -1;
        resp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) drive(1'b0, AW'(i), '0, '0);
            else idle();
            tick();
            if (i < 8) begin
                vectors++;
                if (s_ready !== 1'b1 || s_acc !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready[%0d]: ready=%b required 1", i, s_ready);
                end
            end
            if (s_pop) begin
                pops++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_resp: unexpected response set %0d data %h", s_addr, s_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_addr !== e.addr || s_data !== e.data) begin
                        miscompares++;
                        $display("FAIL b2b_resp: got %0d/%h required %0d/%h", s_addr, s_data, e.addr, e.data);
                    end
                end
            end
        end
        vectors++;
        if (pops != 8 || first_pop != 2 || last_pop != 9) begin
            miscompares++;
            $display("FAIL b2b_timing: pops=%0d first=%0d last=%0d required 8/2/9", pops, first_pop, last_pop);
        end
    endtask

    task automatic test_stall();
        resp_t e;
        resp_ready = 1'b0;
        drive(1'b0, 6'd10, '0, '0);
        tick();
        drive(1'b0, 6'd11, '0, '0);
        tick();
        vectors++;
        if (exp_q.size() != 2) begin
            miscompares++;
            $display("FAIL stall_accepts: accepted=%0d required 2", exp_q.size());
        end
        drive(1'b0, 6'd12, '0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (s_ready !== 1'b0 || s_acc !== 1'b0 || s_valid !== 1'b1
                || s_addr !== exp_q[0].addr || s_data !== exp_q[0].data) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: ready=%b rv=%b got %0d/%h required 0/1 %0d/%h",
                         k, s_ready, s_valid, s_addr, s_data, exp_q[0].addr, exp_q[0].data);
            end
        end
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) begin
                vectors++;
                if (s_acc !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_release_accept: acc=%b required 1", s_acc);
                end
                idle();
            end
            if (s_pop) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall_resp: unexpected response set %0d data %h", s_addr, s_data);
                end else begin
                    e = exp_q.pop_front();
                    if (s_addr !== e.addr || s_data !== e.data) begin
                        miscompares++;
                        $display("FAIL stall_resp: got %0d/%h required %0d/%h", s_addr, s_data, e.addr, e.data);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_missing: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_flush();
        resp_ready = 1'b0;
        drive(1'b0, 6'd20, '0, '0);
        tick();
        drive(1'b0, 6'd21, '0, '0);
        tick();
        idle();
        #2;
        vectors++;
        if (resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_setup: rv=%b required 1", resp_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || resp_data !== '0 || resp_addr !== '0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_async: rv=%b rd=%h ra=%0d done=%b required 0/0/0/0",
                     resp_valid, resp_data, resp_addr, init_done);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        tick();
        wait_init_done();
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (s_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_stale[%0d]: rv=%b set=%0d required 0", k, s_valid, s_addr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        req_addr   = '0;
        idle();
        for (int i = 0; i < NS; i++) ref_mem[i] = pattern(i);
        test_reset();
`ifdef BLOCKRAM_INIT_EN
        test_init_sweep();
        test_init_read();
        test_init_restart();
`endif
        test_write_read();
        test_mask();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
